ram_banked: RTL and testbench
=============================

Name: ram_banked

Overview:
- Parametrised successor to the single-bank dual-port M20K RAM wrapper.
- NUM_BANKS independent simple-dual-port banks behind one banked write port and one banked read port.
- Adds a read-valid pipeline with selectable read latency, a post-reset zero-clear state machine, a `ready` handshake, and optional write-to-read forwarding.
- Used as weight/vector storage in NPU tiles, where several lanes share one addressing front-end.

Parameters:
- MODULE_ID, "", string tag for debug/init naming.
- ID, 0, instance number.
- DW, 32, data width per word.
- DEPTH, 512, words per bank; must be a power of two.
- AW, $clog2(DEPTH), word address width.
- NUM_BANKS, 4, bank count; power of two, at least 1.
- BW, (NUM_BANKS>1)?$clog2(NUM_BANKS):1, bank-select width.
- RD_LAT, 2, read latency in cycles; only 1 or 2 is legal (2 = M20K output register on).
- INIT_CLEAR, 1, 1 = zero all banks after reset before asserting `ready`.
- TARGET_FPGA, `TARGET_FPGA, device family string.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- ready  out  1  block accepts reads/writes
- wr_en  in  1  write strobe
- wr_bank  in  BW  target bank
- wr_addr  in  AW  word address
- wr_data  in  DW  write data
- rd_en  in  1  read request
- rd_bank  in  BW  source bank
- rd_addr  in  AW  word address
- rd_valid  out  1  rd_data holds the result of a request issued RD_LAT cycles earlier
- rd_data  out  DW  read data

Behaviour:
- Single clock domain; rst is asynchronous and active-low.
- While rst is asserted: ready=0, rd_valid=0, rd_data=0, clear counter=0, FSM=S_CLEAR, or S_READY if INIT_CLEAR=0.
- FSM states:
  - S_CLEAR: every cycle, write 0 to address clr_cnt in all banks in parallel; clr_cnt increments.
  - At clr_cnt==DEPTH-1, move to S_READY on the next edge. The clear takes exactly DEPTH cycles.
  - S_READY: ready=1. This state is terminal until the next reset.
  - ready is registered and goes high on the first cycle in S_READY.
- Requests while ready=0:
  - wr_en is ignored, with no memory effect.
  - rd_en is dropped; no rd_valid is ever produced for it.
- Reset asserted mid-clear: the FSM and counter return to their reset values, and the clear restarts from address 0 after release.
- Write: when wr_en && ready, bank wr_bank is written at wr_addr on that clock edge. Other banks are untouched.
- Read: when rd_en && ready, bank rd_bank is read at rd_addr.
  - rd_valid pulses exactly RD_LAT cycles later.
  - rd_data shows the bank output, muxed by the bank select delayed RD_LAT cycles.
- rd_data holds its last value while rd_valid=0. It does not return to 0.
- Back-to-back reads are fully pipelined: one request per cycle, with no bubbles.
- Read and write to different banks, or to different addresses in one bank, in the same cycle: both complete normally.
- Same bank, same address, same cycle: see Optional Feature.
- Write-then-read: a read issued at least one cycle after the write edge returns the new data.
- Banks are M20K simple dual-port (altera_syncram, DUAL_PORT, address_reg_b=CLOCK0, mixed-port read-during-write DONT_CARE).
- RD_LAT=1 selects outdata_reg_b UNREGISTERED; RD_LAT=2 selects CLOCK0.
- Elaboration: illegal RD_LAT, non-power-of-two DEPTH or NUM_BANKS → $error.

Optional Feature:
- Macro: RAM_RD_BYPASS_EN.
- With it: on a same-cycle collision (wr_en && rd_en && wr_bank==rd_bank && wr_addr==rd_addr && ready), a registered collision flag and a wr_data copy are carried through the RD_LAT pipeline. rd_data then returns the new wr_data.
- Without it: rd_data for a colliding read is undefined. The model drives X, and the bench must not check it. rd_valid still pulses.

Decomposition:
- Package npu_ram_pkg holds:
  - RD_LAT legal values as localparams;
  - FSM enum typedef (S_CLEAR, S_READY);
  - the function clog2_min1() used for BW.
- Sub-module ram_bank: one altera_syncram wrapper parametrised by DW/DEPTH/AW/RD_LAT. It is instantiated NUM_BANKS times in a generate loop.
- Top level owns the FSM, clear mux, valid/bank-select pipeline, and bypass.

Test Plan:
- Reset release, INIT_CLEAR=1, DEPTH=512 → ready rises exactly 512 cycles after release; a read of bank 3 addr 0x1FF returns 0.
- Write 0xDEADBEEF bank 1 addr 5, then read next cycle, RD_LAT=2 → rd_valid one pulse 2 cycles later, rd_data=0xDEADBEEF; bank 0 addr 5 reads 0.
- 16 back-to-back reads across banks 0..3 → 16 consecutive rd_valid cycles, data in issue order.
- Same-cycle write 0x12345678 / read, bank 2 addr 7 → with RAM_RD_BYPASS_EN rd_data=0x12345678; without it, only rd_valid is checked.
- Assert rst at clear cycle 200, release → ready=0 during reset; ready rises 512 cycles after release; earlier writes attempted during clear have no effect.
- rd_en/wr_en while ready=0 → no rd_valid ever; memory stays all-zero.

Source files
------------

// File: rtl/npu_ram_pkg.sv
// Shared definitions for the banked NPU RAM: legal read latencies, the
// post-reset clear state machine encoding and a bank-select width helper.
package npu_ram_pkg;

    // Legal read latencies: 1 = bank output unregistered, 2 = output register on
    localparam int unsigned RD_LAT_UNREG = 1;
    localparam int unsigned RD_LAT_REG   = 2;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } ram_state_e;

    // $clog2 that never returns 0, so a single-bank build still has a 1-bit select
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : npu_ram_pkg

// File: rtl/ram_bank.sv
// One simple-dual-port M20K bank (behavioural stand-in for altera_syncram in
// DUAL_PORT mode, read address registered on clk, mixed-port read-during-write
// don't-care).
// Ports:
//   clk      clock
//   i_we     write enable
//   i_waddr  write word address
//   i_wdata  write data
//   i_re     read request (only used to flag same-address collisions)
//   i_raddr  read word address, registered every cycle
//   o_q      read data; RD_LAT=1 -> straight from the array after the address
//            register, RD_LAT=2 -> through an extra output register
module ram_bank #(
    parameter int unsigned DW     = 32,
    parameter int unsigned DEPTH  = 512,
    parameter int unsigned AW     = $clog2(DEPTH),
    parameter int unsigned RD_LAT = 2
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_q
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_raddr;
    logic          r_col;
    logic [DW-1:0] w_q;

    // Array write plus registered read address; the macro has no reset here
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_raddr <= i_raddr;
        r_col   <= i_we & i_re & (i_waddr == i_raddr);
    end

    // Same-address read-during-write is undefined on the device: model it as X
    assign w_q = r_col ? {DW{1'bx}} : r_mem[r_raddr];

    if (RD_LAT == 2) begin : g_out_reg
        logic [DW-1:0] r_q;
        always_ff @(posedge clk) begin
            r_q <= w_q;
        end
        assign o_q = r_q;
    end else begin : g_out_unreg
        assign o_q = w_q;
    end

endmodule : ram_bank

// File: rtl/ram_banked.sv
// NUM_BANKS independent simple-dual-port banks behind one banked write port
// and one banked read port, with a post-reset zero-clear sequence, a ready
// handshake and a fully pipelined read-valid path.
// Optional feature: define RAM_RD_BYPASS_EN to forward wr_data to a read that
// hits the same bank/address in the same cycle; otherwise that read's data is X.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   ready               high once the clear has finished; gates all requests
//   wr_en/bank/addr/data write request
//   rd_en/bank/addr     read request
//   rd_valid/rd_data    read response, RD_LAT cycles after the request edge;
//                       rd_data holds its last value while rd_valid is low
`ifndef TARGET_FPGA
`define TARGET_FPGA "GENERIC"
`endif

module ram_banked
    import npu_ram_pkg::*;
#(
    parameter string       MODULE_ID   = "",
    parameter int          ID          = 0,
    parameter int unsigned DW          = 32,
    parameter int unsigned DEPTH       = 512,
    parameter int unsigned AW          = $clog2(DEPTH),
    parameter int unsigned NUM_BANKS   = 4,
    parameter int unsigned BW          = clog2_min1(NUM_BANKS),
    parameter int unsigned RD_LAT      = 2,
    parameter int unsigned INIT_CLEAR  = 1,
    parameter string       TARGET_FPGA = `TARGET_FPGA
) (
    input  logic          clk,
    input  logic          rst,
    output logic          ready,
    input  logic          wr_en,
    input  logic [BW-1:0] wr_bank,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [BW-1:0] rd_bank,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data
);

    // Elaboration-time parameter checks
    if (!(RD_LAT == RD_LAT_UNREG || RD_LAT == RD_LAT_REG)) begin : g_bad_lat
        $error("ram_banked %s: RD_LAT must be 1 or 2", MODULE_ID);
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("ram_banked %s: DEPTH must be a power of two", MODULE_ID);
    end
    if (NUM_BANKS < 1 || (NUM_BANKS & (NUM_BANKS - 1)) != 0) begin : g_bad_banks
        $error("ram_banked %s: NUM_BANKS must be a power of two", MODULE_ID);
    end
    if (ID < 0) begin : g_bad_id
        $error("ram_banked %s (%s): ID must be non-negative", MODULE_ID, TARGET_FPGA);
    end

    ram_state_e    r_state;
    logic [AW-1:0] r_clr_cnt;
    logic          r_ready;
    logic          w_clearing;
    logic          w_wr_fire;
    logic          w_rd_fire;
    logic [DW-1:0] w_bank_q [NUM_BANKS];
    logic [DW-1:0] w_rd_word;

    logic [RD_LAT-1:0] r_vld_pipe;
    logic [BW-1:0]     r_sel_pipe [RD_LAT];
    logic              r_rd_valid;
    logic [DW-1:0]     r_rd_data;

    assign w_clearing = (r_state == S_CLEAR);
    assign w_wr_fire  = wr_en & r_ready;
    assign w_rd_fire  = rd_en & r_ready;

    // Clear sequencer: one address per cycle across all banks, then ready forever
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= (INIT_CLEAR != 0) ? S_CLEAR : S_READY;
            r_clr_cnt <= '0;
            r_ready   <= 1'b0;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    r_clr_cnt <= r_clr_cnt + AW'(1);
                    if (r_clr_cnt == AW'(DEPTH - 1)) begin
                        r_state <= S_READY;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    // Banks: the clear mux takes over the write port while clearing
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic w_we;
        logic w_re;
        assign w_we = w_clearing | (w_wr_fire & (wr_bank == BW'(b)));
        assign w_re = w_rd_fire & (rd_bank == BW'(b));

        ram_bank #(
            .DW     (DW),
            .DEPTH  (DEPTH),
            .AW     (AW),
            .RD_LAT (RD_LAT)
        ) u_bank (
            .clk     (clk),
            .i_we    (w_we),
            .i_waddr (w_clearing ? r_clr_cnt : wr_addr),
            .i_wdata (w_clearing ? '0 : wr_data),
            .i_re    (w_re),
            .i_raddr (rd_addr),
            .o_q     (w_bank_q[b])
        );
    end

`ifdef RAM_RD_BYPASS_EN
    logic              w_col;
    logic [RD_LAT-1:0] r_col_pipe;
    logic [DW-1:0]     r_byp_pipe [RD_LAT];

    assign w_col = w_wr_fire & rd_en & (wr_bank == rd_bank) & (wr_addr == rd_addr);

    // Collision flag and write data travel alongside the bank read
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_col_pipe <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                r_byp_pipe[i] <= '0;
            end
        end else begin
            r_col_pipe[0] <= w_col;
            r_byp_pipe[0] <= wr_data;
            for (int i = 1; i < RD_LAT; i++) begin
                r_col_pipe[i] <= r_col_pipe[i-1];
                r_byp_pipe[i] <= r_byp_pipe[i-1];
            end
        end
    end
`endif

    // Response word: bank output selected by the delayed bank select
    always_comb begin
        w_rd_word = w_bank_q[r_sel_pipe[RD_LAT-1]];
`ifdef RAM_RD_BYPASS_EN
        if (r_col_pipe[RD_LAT-1]) begin
            w_rd_word = r_byp_pipe[RD_LAT-1];
        end
`endif
    end

    // Valid / bank-select pipeline and registered response
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vld_pipe <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                r_sel_pipe[i] <= '0;
            end
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_vld_pipe[0] <= w_rd_fire;
            r_sel_pipe[0] <= rd_bank;
            for (int i = 1; i < RD_LAT; i++) begin
                r_vld_pipe[i] <= r_vld_pipe[i-1];
                r_sel_pipe[i] <= r_sel_pipe[i-1];
            end
            r_rd_valid <= r_vld_pipe[RD_LAT-1];
            if (r_vld_pipe[RD_LAT-1]) begin
                r_rd_data <= w_rd_word;
            end
        end
    end

    assign ready    = r_ready;
    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_data;

endmodule : ram_banked

// File: tb/tb_ram_banked.sv
// Directed bench for ram_banked at default parameters (DW=32, DEPTH=512,
// NUM_BANKS=4, RD_LAT=2, INIT_CLEAR=1).
module tb_ram_banked;

    localparam int unsigned DW     = 32;
    localparam int unsigned DEPTH  = 512;
    localparam int unsigned AW     = 9;
    localparam int unsigned BW     = 2;
    localparam int unsigned RD_LAT = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          ready;
    logic          wr_en;
    logic [BW-1:0] wr_bank;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic [BW-1:0] rd_bank;
    logic [AW-1:0] rd_addr;
    logic          rd_valid;
    logic [DW-1:0] rd_data;

    int n_tests = 0;
    int n_fail  = 0;

    ram_banked dut (
        .clk      (clk),
        .rst      (rst),
        .ready    (ready),
        .wr_en    (wr_en),
        .wr_bank  (wr_bank),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_bank  (rd_bank),
        .rd_addr  (rd_addr),
        .rd_valid (rd_valid),
        .rd_data  (rd_data)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pat(input int b, input int a);
        return 32'hA000_0000 | 32'(b << 8) | 32'(a);
    endfunction

    task automatic do_write(input int b, input int a, input logic [31:0] d);
        wr_en = 1'b1; wr_bank = BW'(b); wr_addr = AW'(a); wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    // Issue one read; rd_valid must stay low for RD_LAT samples, then pulse once
    task automatic read_check(input int b, input int a, input logic [31:0] exp,
                              input string tag, input bit chk_data);
        rd_en = 1'b1; rd_bank = BW'(b); rd_addr = AW'(a);
        step();
        rd_en = 1'b0;
        for (int k = 0; k < RD_LAT; k++) begin
            check({tag, "_early_valid"}, 32'(rd_valid), 32'd0);
            step();
        end
        check({tag, "_valid"}, 32'(rd_valid), 32'd1);
        if (chk_data) check({tag, "_data"}, rd_data, exp);
        step();
        check({tag, "_pulse_end"}, 32'(rd_valid), 32'd0);
    endtask

    // Run a full clear from reset release, with ignored requests injected mid-clear
    task automatic run_clear(input int b, input int a, input string tag);
        int vcnt;
        vcnt = 0;
        for (int c = 1; c <= DEPTH; c++) begin
            if (c >= 100 && c < 110) begin
                wr_en = 1'b1; wr_bank = BW'(b); wr_addr = AW'(a); wr_data = 32'hBAD0_BAD0;
                rd_en = 1'b1; rd_bank = BW'(b); rd_addr = AW'(a);
            end else begin
                wr_en = 1'b0; rd_en = 1'b0;
            end
            step();
            if (rd_valid) vcnt++;
            if (c == DEPTH - 1) check({tag, "_ready_low_at_511"}, 32'(ready), 32'd0);
            if (c == DEPTH)     check({tag, "_ready_high_at_512"}, 32'(ready), 32'd1);
        end
        check({tag, "_no_valid_during_clear"}, 32'(vcnt), 32'd0);
    endtask

    logic [31:0] held;

    initial begin
        rst = 1'b0;
        wr_en = 1'b0; wr_bank = '0; wr_addr = '0; wr_data = '0;
        rd_en = 1'b0; rd_bank = '0; rd_addr = '0;
        step(); step();
        check("reset_ready", 32'(ready), 32'd0);
        check("reset_rd_valid", 32'(rd_valid), 32'd0);
        check("reset_rd_data", rd_data, 32'd0);

        // First clear, interrupted by reset at clear cycle 200
        rst = 1'b1;
        for (int c = 1; c <= 200; c++) begin
            if (c >= 150 && c < 160) begin
                wr_en = 1'b1; wr_bank = 2'd1; wr_addr = 9'd10; wr_data = 32'hBAD0_0001;
                rd_en = 1'b1; rd_bank = 2'd1; rd_addr = 9'd10;
            end else begin
                wr_en = 1'b0; rd_en = 1'b0;
            end
            step();
            check("clear1_no_valid", 32'(rd_valid), 32'd0);
        end
        check("clear1_ready_low", 32'(ready), 32'd0);
        rst = 1'b0;
        #1;
        check("midclear_rst_ready", 32'(ready), 32'd0);
        step(); step();
        check("midclear_rst_ready_held", 32'(ready), 32'd0);
        check("midclear_rst_valid", 32'(rd_valid), 32'd0);

        // Restarted clear must take the full 512 cycles again
        rst = 1'b1;
        run_clear(2, 20, "clear2");

        // Memory all-zero, including locations targeted while not ready
        read_check(3, 9'h1FF, 32'd0, "b3_a1ff_zero", 1'b1);
        read_check(2, 20, 32'd0, "ignored_wr_b2_a20", 1'b1);
        read_check(1, 10, 32'd0, "ignored_wr_b1_a10", 1'b1);

        // Write then read next cycle; neighbouring bank untouched
        do_write(1, 5, 32'hDEAD_BEEF);
        read_check(1, 5, 32'hDEAD_BEEF, "wr_rd_b1_a5", 1'b1);
        read_check(0, 5, 32'd0, "other_bank_b0_a5", 1'b1);

        // rd_data holds after the pulse
        held = rd_data;
        step(); step();
        check("rd_data_hold_valid", 32'(rd_valid), 32'd0);
        check("rd_data_hold", rd_data, 32'd0);
        check("rd_data_hold_prev", rd_data, held);

        // 16 back-to-back reads across banks 0..3
        for (int i = 0; i < 16; i++) do_write(i % 4, i / 4, pat(i % 4, i / 4));
        for (int c = 0; c < 16 + RD_LAT + 1; c++) begin
            if (c < 16) begin
                rd_en = 1'b1; rd_bank = BW'(c % 4); rd_addr = AW'(c / 4);
            end else begin
                rd_en = 1'b0;
            end
            step();
            if (c >= RD_LAT && c - RD_LAT < 16) begin
                check($sformatf("b2b_valid_%0d", c - RD_LAT), 32'(rd_valid), 32'd1);
                check($sformatf("b2b_data_%0d", c - RD_LAT), rd_data,
                      pat((c - RD_LAT) % 4, (c - RD_LAT) / 4));
            end else begin
                check($sformatf("b2b_idle_%0d", c), 32'(rd_valid), 32'd0);
            end
        end

        // Same-bank different-address read/write in one cycle
        wr_en = 1'b1; wr_bank = 2'd0; wr_addr = 9'd1; wr_data = 32'h5555_AAAA;
        read_check(0, 0, pat(0, 0), "same_bank_diff_addr", 1'b1);
        wr_en = 1'b0;
        read_check(0, 1, 32'h5555_AAAA, "same_bank_diff_addr_wr", 1'b1);

        // Different-bank read/write in one cycle
        wr_en = 1'b1; wr_bank = 2'd3; wr_addr = 9'd2; wr_data = 32'h0F0F_F0F0;
        read_check(2, 2, pat(2, 2), "diff_bank_rd", 1'b1);
        wr_en = 1'b0;
        read_check(3, 2, 32'h0F0F_F0F0, "diff_bank_wr", 1'b1);

        // Same-cycle collision, bank 2 addr 7
        wr_en = 1'b1; wr_bank = 2'd2; wr_addr = 9'd7; wr_data = 32'h1234_5678;
`ifdef RAM_RD_BYPASS_EN
        read_check(2, 7, 32'h1234_5678, "collision_bypass", 1'b1);
`else
        read_check(2, 7, 32'h0, "collision_nobypass", 1'b0);
`endif
        wr_en = 1'b0;
        read_check(2, 7, 32'h1234_5678, "collision_followup", 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_ram_banked
